// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// Optional per-requester transfer counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                          stat_clr,
  output logic [NUM_REQ*16-1:0]         stat_count,
`endif
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_w_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(BURST_LEN + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t         state_r, state_s;
  logic [IDW-1:0] owner_r, owner_s;
  logic [IDW-1:0] rr_ptr_r, rr_ptr_s;
  logic [BCW-1:0] beat_cnt_r, beat_cnt_s;
  logic           owner_valid_s;
  logic           xfer_s;

  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] v);
    if (int'(v) == NUM_REQ - 1) begin
      inc_wrap = '0;
    end else begin
      inc_wrap = v + IDW'(1);
    end
  endfunction

  // Descending scan so the requester closest to start (in ring order) wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                             input logic [IDW-1:0] start);
    int idx;
    rr_pick = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (v[idx[IDW-1:0]]) begin
        rr_pick = idx[IDW-1:0];
      end else begin
        rr_pick = rr_pick;
      end
    end
  endfunction

  // State, owner, pointer and beat registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      owner_r    <= '0;
      rr_ptr_r   <= '0;
      beat_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      owner_r    <= owner_s;
      rr_ptr_r   <= rr_ptr_s;
      beat_cnt_r <= beat_cnt_s;
    end
  end

  assign owner_valid_s = req_valid[owner_r];
  assign fifo_data_in  = req_data[int'(owner_r)*DATA_WIDTH +: DATA_WIDTH];

  // Next-state, handshake and FIFO write control.
  always_comb begin
    state_s    = state_r;
    owner_s    = owner_r;
    rr_ptr_s   = rr_ptr_r;
    beat_cnt_s = beat_cnt_r;
    req_ready  = '0;
    fifo_w_en  = 1'b0;
    xfer_s     = 1'b0;
    grant_id   = '0;
    busy       = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          state_s    = LOCK;
          owner_s    = rr_pick(req_valid, rr_ptr_r);
          beat_cnt_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      LOCK: begin
        busy               = 1'b1;
        grant_id           = owner_r;
        req_ready[owner_r] = !fifo_full;
        xfer_s             = owner_valid_s & !fifo_full;
        fifo_w_en          = xfer_s;
        // Release hands straight to the next winner; the old owner is searched last.
        if ((xfer_s && (beat_cnt_r == LAST_BEAT)) || !owner_valid_s) begin
          rr_ptr_s   = inc_wrap(owner_r);
          beat_cnt_s = '0;
          if (|req_valid) begin
            state_s = LOCK;
            owner_s = rr_pick(req_valid, inc_wrap(owner_r));
          end else begin
            state_s = IDLE;
            owner_s = '0;
          end
        end else if (xfer_s) begin
          beat_cnt_s = beat_cnt_r + BCW'(1);
        end else begin
          beat_cnt_s = beat_cnt_r;
        end
      end
      default: begin
        state_s    = IDLE;
        owner_s    = '0;
        beat_cnt_s = '0;
      end
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [15:0] cnt_r [NUM_REQ];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 16'd1;
    end
  endfunction

  // Per-requester saturating transfer counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_r[i] <= 16'd0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_r[i] <= 16'd0;
    end else if (xfer_s) begin
      cnt_r[owner_r] <= sat_inc(cnt_r[owner_r]);
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_r[i] <= cnt_r[i];
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_count[g*16 +: 16] = cnt_r[g];
  end
`endif

endmodule
